// File: rtl/light_pattern_seq.sv
// LED pattern sequencer: walk-left, walk-right, bounce and fill animations
// with programmable step length, pass count and pause/resume control.
module light_pattern_seq #(
    parameter int unsigned N_LEDS      = 4,
    parameter int unsigned STEP_CYCLES = 1,
    parameter int unsigned LOOPS       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              play,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] leds,
    output logic              busy,
    output logic              paused,
    output logic              done
);

    localparam int unsigned TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned SW = $clog2(2 * N_LEDS);
    localparam int unsigned PW = (LOOPS > 0) ? $clog2(LOOPS + 1) : 1;

    localparam logic [TW-1:0] TIMER_LAST  = TW'(STEP_CYCLES - 1);
    localparam logic [SW-1:0] LINE_LAST   = SW'(N_LEDS - 1);
    localparam logic [SW-1:0] BOUNCE_LAST = SW'(2 * N_LEDS - 3);
    localparam logic [SW-1:0] BOUNCE_TURN = SW'(2 * N_LEDS - 2);
    localparam logic [PW-1:0] PASS_LAST   = PW'((LOOPS > 0) ? (LOOPS - 1) : 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    localparam logic [1:0] M_LEFT   = 2'd0;
    localparam logic [1:0] M_RIGHT  = 2'd1;
    localparam logic [1:0] M_BOUNCE = 2'd2;
    localparam logic [1:0] M_FILL   = 2'd3;

    logic [1:0]        state, state_nxt;
    logic [TW-1:0]     timer, timer_nxt;
    logic [SW-1:0]     step, step_nxt;
    logic [PW-1:0]     pass, pass_nxt;
    logic [1:0]        mode_q, mode_nxt;
    logic [N_LEDS-1:0] leds_nxt;
    logic              busy_nxt, paused_nxt, done_nxt;
    logic [SW-1:0]     step_last;
    logic              finish;

    // LED image for animation m at step index k
    function automatic logic [N_LEDS-1:0] pattern(input logic [1:0] m, input logic [SW-1:0] k);
        logic [SW-1:0]     pos;
        logic [N_LEDS-1:0] ones;
        ones = '1;
        pos  = k;
        case (m)
            M_RIGHT:  pos = LINE_LAST - k;
            M_BOUNCE: if (k > LINE_LAST) pos = BOUNCE_TURN - k;
            default:  pos = k;
        endcase
        if (m == M_FILL) pattern = ones >> (LINE_LAST - k);
        else             pattern = N_LEDS'(1) << pos;
    endfunction

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        step_nxt   = step;
        pass_nxt   = pass;
        mode_nxt   = mode_q;
        leds_nxt   = leds;
        busy_nxt   = busy;
        paused_nxt = paused;
        done_nxt   = 1'b0;
        finish     = 1'b0;
        step_last  = (mode_q == M_BOUNCE) ? BOUNCE_LAST : LINE_LAST;

        // start wins over play in every state and restarts from scratch
        if (start) begin
            state_nxt  = S_RUN;
            mode_nxt   = mode;
            timer_nxt  = '0;
            step_nxt   = '0;
            pass_nxt   = '0;
            leds_nxt   = pattern(mode, '0);
            busy_nxt   = 1'b1;
            paused_nxt = 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    // the pausing edge still counts, so each step keeps exactly STEP_CYCLES running cycles
                    if (timer == TIMER_LAST) begin
                        timer_nxt = '0;
                        if (step == step_last) begin
                            step_nxt = '0;
                            if (LOOPS != 0) begin
                                if (pass == PASS_LAST) finish = 1'b1;
                                else                   pass_nxt = pass + 1'b1;
                            end
                        end else begin
                            step_nxt = step + 1'b1;
                        end
                        leds_nxt = pattern(mode_q, step_nxt);
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end

                    if (finish) begin
                        state_nxt  = S_IDLE;
                        timer_nxt  = '0;
                        step_nxt   = '0;
                        pass_nxt   = '0;
                        leds_nxt   = '0;
                        busy_nxt   = 1'b0;
                        paused_nxt = 1'b0;
                        done_nxt   = 1'b1;
                    end else if (play) begin
                        state_nxt  = S_PAUSE;
                        paused_nxt = 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (play) begin
                        state_nxt  = S_RUN;
                        paused_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt  = S_IDLE;
                    leds_nxt   = '0;
                    busy_nxt   = 1'b0;
                    paused_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            timer  <= '0;
            step   <= '0;
            pass   <= '0;
            mode_q <= '0;
            leds   <= '0;
            busy   <= 1'b0;
            paused <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            step   <= step_nxt;
            pass   <= pass_nxt;
            mode_q <= mode_nxt;
            leds   <= leds_nxt;
            busy   <= busy_nxt;
            paused <= paused_nxt;
            done   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_light_pattern_seq.sv
// Directed bench for light_pattern_seq: one instance with a single pass and one
// with two passes, both 4 LEDs and 2 cycles per step, driven by shared stimulus.
module tb_light_pattern_seq;

    logic       clk = 1'b0;
    logic       reset, start, play;
    logic [1:0] mode;

    logic [3:0] leds_a, leds_b;
    logic       busy_a, busy_b, paused_a, paused_b, done_a, done_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    light_pattern_seq #(.N_LEDS(4), .STEP_CYCLES(2), .LOOPS(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .play(play), .mode(mode),
        .leds(leds_a), .busy(busy_a), .paused(paused_a), .done(done_a)
    );

    light_pattern_seq #(.N_LEDS(4), .STEP_CYCLES(2), .LOOPS(2)) dut_b (
        .clk(clk), .reset(reset), .start(start), .play(play), .mode(mode),
        .leds(leds_b), .busy(busy_b), .paused(paused_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // packed status word {done, paused, busy, leds}
    function automatic logic [31:0] st(input logic d, input logic p, input logic b, input logic [3:0] l);
        return {25'd0, d, p, b, l};
    endfunction

    function automatic logic [31:0] obs_a();
        return {25'd0, done_a, paused_a, busy_a, leds_a};
    endfunction

    function automatic logic [31:0] obs_b();
        return {25'd0, done_b, paused_b, busy_b, leds_b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    logic [3:0] walk [4]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] bseq [6]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};

    initial begin
        reset = 1'b1;
        start = 1'b0;
        play  = 1'b0;
        mode  = 2'd0;

        // reset and idle behaviour
        tick();
        tick();
        check("reset_a", obs_a(), st(0, 0, 0, 4'b0000));
        check("reset_b", obs_b(), st(0, 0, 0, 4'b0000));
        reset = 1'b0;
        play  = 1'b1;
        tick();
        play  = 1'b0;
        check("idle_play", obs_a(), st(0, 0, 0, 4'b0000));
        tick();
        check("idle_hold", obs_a(), st(0, 0, 0, 4'b0000));

        // walk-left, single pass
        pulse_start(2'd0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("walk_k%0d", k), obs_a(), st(0, 0, 1, walk[k/2]));
            tick();
        end
        check("walk_done", obs_a(), st(1, 0, 0, 4'b0000));
        tick();
        check("walk_after", obs_a(), st(0, 0, 0, 4'b0000));

        // bounce, two passes
        do_reset();
        pulse_start(2'd2);
        for (int k = 0; k < 24; k++) begin
            check($sformatf("bounce_k%0d", k), obs_b(), st(0, 0, 1, bseq[(k/2) % 6]));
            tick();
        end
        check("bounce_done", obs_b(), st(1, 0, 0, 4'b0000));

        // fill with pause and resume
        do_reset();
        pulse_start(2'd3);
        check("fill_s0", obs_a(), st(0, 0, 1, 4'b0001));
        tick();
        tick();
        check("fill_s1", obs_a(), st(0, 0, 1, 4'b0011));
        play = 1'b1;
        tick();
        play = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("pause_i%0d", i), obs_a(), st(0, 1, 1, 4'b0011));
            if (i == 9) play = 1'b1;
            tick();
        end
        play = 1'b0;
        check("resume_0011", obs_a(), st(0, 0, 1, 4'b0011));
        tick();
        check("resume_0111a", obs_a(), st(0, 0, 1, 4'b0111));
        tick();
        check("resume_0111b", obs_a(), st(0, 0, 1, 4'b0111));
        tick();
        check("resume_1111a", obs_a(), st(0, 0, 1, 4'b1111));
        tick();
        check("resume_1111b", obs_a(), st(0, 0, 1, 4'b1111));
        tick();
        check("fill_done", obs_a(), st(1, 0, 0, 4'b0000));

        // restart mid-run with a new mode
        do_reset();
        pulse_start(2'd0);
        repeat (4) tick();
        check("restart_pre", obs_a(), st(0, 0, 1, 4'b0100));
        pulse_start(2'd1);
        check("restart_0", obs_a(), st(0, 0, 1, 4'b1000));
        tick();
        check("restart_1", obs_a(), st(0, 0, 1, 4'b1000));
        tick();
        check("restart_2", obs_a(), st(0, 0, 1, 4'b0100));

        // start on the terminal edge suppresses done
        do_reset();
        pulse_start(2'd0);
        repeat (7) tick();
        check("term_pre", obs_a(), st(0, 0, 1, 4'b1000));
        pulse_start(2'd3);
        check("term_restart", obs_a(), st(0, 0, 1, 4'b0001));

        // start beats play, in RUN and in PAUSE
        do_reset();
        pulse_start(2'd0);
        tick();
        tick();
        start = 1'b1;
        play  = 1'b1;
        mode  = 2'd2;
        tick();
        start = 1'b0;
        play  = 1'b0;
        check("prio_run", obs_a(), st(0, 0, 1, 4'b0001));
        play = 1'b1;
        tick();
        play = 1'b0;
        check("prio_paused", obs_a(), st(0, 1, 1, 4'b0001));
        start = 1'b1;
        play  = 1'b1;
        mode  = 2'd1;
        tick();
        start = 1'b0;
        play  = 1'b0;
        check("prio_pause", obs_a(), st(0, 0, 1, 4'b1000));
        tick();
        tick();
        check("prio_step", obs_a(), st(0, 0, 1, 4'b0100));

        // reset mid-run
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_a", obs_a(), st(0, 0, 0, 4'b0000));
        check("midreset_b", obs_b(), st(0, 0, 0, 4'b0000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/light_pattern_seq.md
# light_pattern_seq

Parametrised LED pattern sequencer, successor to the fixed 4-LED light pattern block. Generates one of four selectable animations on an `N_LEDS`-wide LED bus:
- walk-left
- walk-right
- bounce
- fill

Each pattern is held for a programmable number of clock cycles and the sequence repeats a programmable number of passes. It sits between the debounced board buttons (`start`, `play`) and the LED pins, and reports `busy`, `paused` and `done` status to the top level.

## Interface
- `N_LEDS`, 4: number of LED outputs; legal range 2..32.
- `STEP_CYCLES`, 1: clock cycles each pattern is held; legal range ≥1.
- `LOOPS`, 2: full passes per run; 0 = run forever until reset or restart.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `start` in 1: one-cycle pulse; begins (or restarts) a run.
- `play` in 1: one-cycle pulse; toggles pause while a run is active.
- `mode` in 2: animation select, sampled only on an accepted `start`.
- `leds` out `N_LEDS`: LED drive, bit 0 = rightmost LED.
- `busy` out 1: high while in RUN or PAUSE.
- `paused` out 1: high while in PAUSE.
- `done` out 1: one-cycle pulse when the final pass completes.

## Operation
- **States:** IDLE, RUN, PAUSE.
- **Reset:**
  - All outputs are 0: `leds`=0, `busy`=0, `paused`=0, `done`=0.
  - Next state is IDLE; step timer, step index and pass counter are cleared.
- **IDLE:**
  - `leds`=0; `play` is ignored.
  - `start`=1 → RUN: latch `mode`, step index=0, pass=0, timer=0.
- **RUN:**
  - Timer counts 0..`STEP_CYCLES`-1.
  - At terminal count the step index advances and the timer returns to 0.
  - At the end of the last step of a pass, the pass counter increments.
- **PAUSE:**
  - Timer, step index, pass counter and `leds` are frozen.
  - `play` → RUN, resuming with the same timer value.
- **`play` in RUN** → PAUSE.
- **`start` in RUN or PAUSE:** restart from step 0, pass 0, timer 0, re-latch `mode`, next state RUN.
- **`start` and `play` together** (in any state): `start` wins and `play` is ignored.
- **Patterns** (k = step index):
  - `mode`=0, walk-left: `leds`=1<<k, k=0..N-1; N steps per pass.
  - `mode`=1, walk-right: `leds`=1<<(N-1-k); N steps per pass.
  - `mode`=2, bounce: one-hot position goes 0,1,…,N-1,N-2,…,1; 2N-2 steps per pass. The next pass restarts at position 0 without repeating it.
  - `mode`=3, fill: `leds`=(2^(k+1))-1, i.e. 1, 3, 7, …, all-ones; N steps per pass.
- **Run completion** (`LOOPS`≠0): when the final step of pass `LOOPS`-1 reaches terminal count:
  - next cycle: `done`=1 for exactly one cycle, `leds`=0, `busy`=0, state is IDLE.
  - A `start` in that terminal cycle takes priority: a restart occurs and `done` is not pulsed.
- **`LOOPS`=0:**
  - Passes wrap indefinitely and `done` never asserts.
  - The pass counter is not incremented, so no overflow is possible.
- **Counter widths:**
  - Timer: clog2(`STEP_CYCLES`), minimum 1 bit.
  - Step index: clog2(2N), enough for the bounce mode.
  - Pass counter: clog2(`LOOPS`+1).
  - No counter exceeds its terminal value.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Latency from an accepted `start`:
  - `start` high at edge t → `busy`=1 and `leds`=first pattern from edge t+1.
  - Each pattern is visible for exactly `STEP_CYCLES` cycles.
- Latency from `play`:
  - `play` at edge t → `paused` changes at t+1.
  - When pausing, `leds` holds the value shown at t+1.
  - A pause shorter than one cycle is impossible; the step in progress keeps its remaining cycles after resume.
- **Run length:** (steps per pass × `STEP_CYCLES` × `LOOPS`) cycles from the first pattern to the `done` cycle.
- **Reset mid-run:** outputs are 0 at the next edge; any pending `done` is suppressed.
- `start`/`play` held high for multiple cycles are treated as a pulse every cycle. Upstream logic is responsible for supplying one-cycle pulses.

## Test plan
All scenarios use `N_LEDS`=4, `STEP_CYCLES`=2, `LOOPS`=1 unless stated.
- **Reset:** hold `reset` for 2 cycles, pulse `play` → `leds`=0000, `busy`=0, `paused`=0, `done`=0; state stays IDLE.
- **Walk-left:** pulse `start` with `mode`=0 → `leds` is 0001, 0010, 0100, 1000, each for 2 cycles. On the 9th cycle after `start`: `done`=1, `leds`=0000, `busy`=0.
- **Bounce:** `mode`=2, `LOOPS`=2 → `leds` sequence is 0001, 0010, 0100, 1000, 0100, 0010, then the same 6 again; 24 cycles total, then `done`.
- **Pause:** `mode`=3, `play` 3 cycles after `start`:
  - `paused`=1 and `leds`=0011 frozen for 10 cycles.
  - Second `play` → 0011 completes its remaining cycle, then 0111 and 1111 follow.
- **Restart:** pulse `start` with `mode`=1 while `leds`=0100 in `mode`=0 → next cycle `leds`=1000, `busy`=1, with no `done` pulse.
- **Priority:** `start` and `play` in the same cycle during RUN → restart with `paused`=0. Assert `reset` mid-run → all outputs 0 at the next edge.
